pipe_stage_buf: RTL and testbench

Parametrised, elastic pipeline-stage register that replaces fixed, enable-only stage latches between pipeline stages, for example EX to MEM. It carries an opaque WIDTH-bit payload bundle plus a sideband halt bit through a DEPTH-entry circular buffer with valid/ready handshaking on both sides. It adds behaviour the fixed latches lack:
- synchronous flush, which squashes everything in flight;
- bubble-safe output, which is zero when empty;
- a sticky halt that stops intake once a halting instruction has entered the stage.

---
 rtl/pipe_stage_buf.sv | 101 ++++++++++
 tb/tb_pipe_stage_buf.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer carrying payload plus halt bit, with flush and sticky halt.
// Latency 1 cycle push-to-head; in_ready depends on registered state only (drops when full or halted).
module pipe_stage_buf #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             halted
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;
    logic            push;
    logic            pop;
    logic [WIDTH:0]  head;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count_q < FULL_CNT) & ~halted_q;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem_q[rp_q];
    assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
    assign out_halt  = out_valid & head[WIDTH];
    assign count     = count_q;
    assign halted    = halted_q;

    always_comb begin
        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            wp_d     = '0;
            rp_d     = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (push) begin
                wp_d = ptr_inc(wp_q);
            end
            if (pop) begin
                rp_d = ptr_inc(rp_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && in_halt) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage is not reset; out_valid gating keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wp_q] <= {in_halt, in_data};
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2/WIDTH=64 main instance, DEPTH=3/WIDTH=8 instance for pointer wrap.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_halt;
    logic [63:0] in_data;
    logic        out_valid, out_ready, out_halt;
    logic [63:0] out_data;
    logic        flush;
    logic [1:0]  count;
    logic        halted;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, out_halt3, halted3;
    logic [7:0]  in_data3, out_data3;
    logic [1:0]  count3;
    logic        in_halt3 = 1'b0;
    logic        flush3 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
        .flush(flush), .count(count), .halted(halted)
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_halt(in_halt3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_halt(out_halt3),
        .flush(flush3), .count(count3), .halted(halted3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_halt, count, in_ready, halted, out_data} !== {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%b h=%b cnt=%0d rdy=%b hlt=%b d=%h exp v=0 h=0 cnt=0 rdy=1 hlt=0 d=0",
                     out_valid, out_halt, count, in_ready, halted, out_data);
        end
        checks++;
        if ({out_valid3, count3, in_ready3} !== {1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state3 got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=1", out_valid3, count3, in_ready3);
        end
        #6 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({out_valid, out_halt, count, in_ready, halted, out_data} !== {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 64'h0}) begin
                errors++;
                $display("FAIL idle_%0d got v=%b cnt=%0d rdy=%b d=%h exp v=0 cnt=0 rdy=1 d=0",
                         i, out_valid, count, in_ready, out_data);
            end
        end
    endtask

    task automatic test_streaming();
        int pops = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready_%0d got %b exp 1", i, in_ready);
            end
            if (out_valid && out_ready) pops++;
            step();
            checks++;
            if ({out_valid, count, out_data} !== {1'b1, 2'd1, 64'(i)}) begin
                errors++;
                $display("FAIL stream_out_%0d got v=%b cnt=%0d d=%h exp v=1 cnt=1 d=%h",
                         i, out_valid, count, out_data, 64'(i));
            end
        end
        in_valid = 1'b0;
        if (out_valid && out_ready) pops++;
        step();
        checks++;
        if ({out_valid, count, pops} !== {1'b0, 2'd0, 32'd32}) begin
            errors++;
            $display("FAIL stream_drain got v=%b cnt=%0d pops=%0d exp v=0 cnt=0 pops=32", out_valid, count, pops);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcv  = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        in_data = 64'hB;
        step();
        checks++;
        if ({count, in_ready, out_data} !== {2'd2, 1'b0, 64'hA}) begin
            errors++;
            $display("FAIL bp_full got cnt=%0d rdy=%b d=%h exp cnt=2 rdy=0 d=a", count, in_ready, out_data);
        end
        in_data = 64'hC;
        step();
        checks++;
        if ({count, in_ready, out_data} !== {2'd2, 1'b0, 64'hA}) begin
            errors++;
            $display("FAIL bp_hold got cnt=%0d rdy=%b d=%h exp cnt=2 rdy=0 d=a", count, in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({count, in_ready, out_data} !== {2'd1, 1'b1, 64'hB}) begin
            errors++;
            $display("FAIL bp_pop1 got cnt=%0d rdy=%b d=%h exp cnt=1 rdy=1 d=b", count, in_ready, out_data);
        end
        step();
        checks++;
        if ({count, out_valid, out_data} !== {2'd1, 1'b1, 64'hC}) begin
            errors++;
            $display("FAIL bp_pop2 got cnt=%0d v=%b d=%h exp cnt=1 v=1 d=c", count, out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({count, out_valid} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL bp_empty got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
        end
        out_ready = 1'b0;

        // DEPTH=3: fill, then drain with gaps so both pointers wrap several times
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            in_valid3  = (sent < 10);
            in_data3   = 8'(8'h10 + sent);
            out_ready3 = (cyc >= 4) && (cyc % 3 != 2);
            if (out_valid3 && out_ready3) begin
                checks++;
                if (out_data3 !== 8'(8'h10 + rcv)) begin
                    errors++;
                    $display("FAIL wrap_data_%0d got %h exp %h", rcv, out_data3, 8'(8'h10 + rcv));
                end
                rcv++;
            end
            if (in_valid3 && in_ready3) sent++;
            step();
            checks++;
            if (count3 !== 2'(sent - rcv)) begin
                errors++;
                $display("FAIL wrap_count_c%0d got %0d exp %0d", cyc, count3, sent - rcv);
            end
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        checks++;
        if (rcv != 10) begin
            errors++;
            $display("FAIL wrap_total got %0d exp 10", rcv);
        end
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        in_halt   = 1'b1;
        step();
        checks++;
        if ({halted, in_ready, count, out_halt, out_data} !== {1'b1, 1'b0, 2'd1, 1'b1, 64'h5}) begin
            errors++;
            $display("FAIL halt_set got hlt=%b rdy=%b cnt=%0d oh=%b d=%h exp hlt=1 rdy=0 cnt=1 oh=1 d=5",
                     halted, in_ready, count, out_halt, out_data);
        end
        in_data = 64'h6;
        in_halt = 1'b0;
        step();
        checks++;
        if ({count, out_data} !== {2'd1, 64'h5}) begin
            errors++;
            $display("FAIL halt_block got cnt=%0d d=%h exp cnt=1 d=5", count, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_halt, out_data, halted, in_ready} !== {1'b0, 1'b0, 64'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_drain got v=%b oh=%b d=%h hlt=%b rdy=%b exp v=0 oh=0 d=0 hlt=1 rdy=0",
                     out_valid, out_halt, out_data, halted, in_ready);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        repeat (3) step();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky got %b exp 1", halted);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({halted, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL halt_clear got hlt=%b rdy=%b cnt=%0d exp hlt=0 rdy=1 cnt=0", halted, in_ready, count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h7;
        step();
        in_data = 64'h8;
        step();
        flush     = 1'b1;
        in_data   = 64'h9;
        in_halt   = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_halt  = 1'b0;
        checks++;
        if ({count, out_valid, out_data, halted, in_ready} !== {2'd0, 1'b0, 64'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_full got cnt=%0d v=%b d=%h hlt=%b rdy=%b exp cnt=0 v=0 d=0 hlt=0 rdy=1",
                     count, out_valid, out_data, halted, in_ready);
        end
        // Flush with a live halting push: the push must be discarded and halt stay clear
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        flush   = 1'b1;
        in_data = 64'h9;
        in_halt = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_halt  = 1'b0;
        checks++;
        if ({count, halted, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_halt got cnt=%0d hlt=%b rdy=%b exp cnt=0 hlt=0 rdy=1", count, halted, in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL flush_no_leak got v=%b d=%h exp v=0 d=0", out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h21;
        step();
        in_data = 64'h22;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin
            errors++;
            $display("FAIL arst_pre got cnt=%0d exp 2", count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, count, out_data, in_ready} !== {1'b0, 2'd0, 64'h0, 1'b1}) begin
            errors++;
            $display("FAIL arst_immediate got v=%b cnt=%0d d=%h rdy=%b exp v=0 cnt=0 d=0 rdy=1",
                     out_valid, count, out_data, in_ready);
        end
        #2 rst = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h33;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, count, out_data} !== {1'b1, 2'd1, 64'h33}) begin
            errors++;
            $display("FAIL arst_resume got v=%b cnt=%0d d=%h exp v=1 cnt=1 d=33", out_valid, count, out_data);
        end
        step();
        checks++;
        if ({out_valid, count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL arst_drain got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count);
        end
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_halt    = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        out_ready3 = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_halt();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
